// File: rtl/feature_frame_assembler.sv
// rtl/feature_frame_assembler.sv - serial channel beats to packed, double-buffered feature frames
module feature_frame_assembler #(
    parameter int NUM_CHANNEL   = 214,
    parameter int CHANNEL_WIDTH = 2,
    parameter int CH_CNT_WIDTH  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ch_valid,
    output logic                                 ch_ready,
    input  logic [CHANNEL_WIDTH-1:0]             ch_data,
    input  logic                                 ch_last,
    output logic                                 fout_valid,
    input  logic                                 fout_ready,
    output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
    output logic                                 frame_err
);

    localparam int FRAME_WIDTH = NUM_CHANNEL * CHANNEL_WIDTH;
    localparam logic [CH_CNT_WIDTH-1:0] LAST_CNT = CH_CNT_WIDTH'(NUM_CHANNEL - 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CH_CNT_WIDTH-1:0] count;
    logic [CH_CNT_WIDTH-1:0] count_nxt;
    logic [FRAME_WIDTH-1:0]  fill_buf;
    logic [FRAME_WIDTH-1:0]  fill_merged;
    logic [FRAME_WIDTH-1:0]  out_buf;
    logic                    out_valid;
    logic                    err_q;
    logic                    err_nxt;
    logic                    fill_wr;
    logic                    load_from_beat;
    logic                    load_from_hold;
    logic                    out_free;

    // The output register can take a new frame if it is empty or is being consumed this cycle.
    assign out_free     = ~out_valid | fout_ready;
    assign fout_valid   = out_valid;
    assign features_top = out_buf;
    assign frame_err    = err_q;

    // Fill buffer with the current beat dropped into its slot; channel 0 lands in the MSBs.
    always_comb begin
        fill_merged = fill_buf;
        for (int i = 0; i < NUM_CHANNEL; i++) begin
            if (count == CH_CNT_WIDTH'(i)) begin
                fill_merged[(NUM_CHANNEL - i) * CHANNEL_WIDTH - 1 -: CHANNEL_WIDTH] = ch_data;
            end
        end
    end

    // Next-state, beat acceptance and framing checks.
    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        ch_ready       = 1'b0;
        fill_wr        = 1'b0;
        load_from_beat = 1'b0;
        load_from_hold = 1'b0;
        err_nxt        = 1'b0;
        case (state)
            ST_FILL: begin
                ch_ready = 1'b1;
                if (ch_valid) begin
                    fill_wr = 1'b1;
                    if (count == LAST_CNT) begin
                        if (ch_last) begin
                            count_nxt = '0;
                            if (out_free) begin
                                load_from_beat = 1'b1;
                            end else begin
                                state_nxt = ST_HOLD;
                            end
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_DRAIN;
                        end
                    end else if (ch_last) begin
                        err_nxt   = 1'b1;
                        count_nxt = '0;
                    end else begin
                        count_nxt = count + CH_CNT_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                ch_ready = 1'b1;
                if (ch_valid && ch_last) begin
                    count_nxt = '0;
                    state_nxt = ST_FILL;
                end
            end
            ST_HOLD: begin
                if (out_free) begin
                    load_from_hold = 1'b1;
                    count_nxt      = '0;
                    state_nxt      = ST_FILL;
                end
            end
            default: begin
                count_nxt = '0;
                state_nxt = ST_FILL;
            end
        endcase
    end

    // State, channel counter and error pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FILL;
            count <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            err_q <= err_nxt;
        end
    end

    // Fill buffer collects beats of the frame under construction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_buf <= '0;
        end else if (fill_wr) begin
            fill_buf <= fill_merged;
        end
    end

    // Output register: loads a completed frame directly or from HOLD, clears valid after handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_buf   <= '0;
            out_valid <= 1'b0;
        end else if (load_from_beat) begin
            out_buf   <= fill_merged;
            out_valid <= 1'b1;
        end else if (load_from_hold) begin
            out_buf   <= fill_buf;
            out_valid <= 1'b1;
        end else if (fout_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_feature_frame_assembler.sv
// tb/tb_feature_frame_assembler.sv - directed self-checking bench for feature_frame_assembler
module tb_feature_frame_assembler;

    localparam int N  = 214;
    localparam int W  = 2;
    localparam int FW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          ch_valid;
    logic          ch_ready;
    logic [W-1:0]  ch_data;
    logic          ch_last;
    logic          fout_valid;
    logic          fout_ready;
    logic [FW-1:0] features_top;
    logic          frame_err;

    int            checks   = 0;
    int            failures = 0;
    int            err_cnt  = 0;
    logic [FW-1:0] out_q[$];

    always #5 clk = ~clk;

    feature_frame_assembler #(
        .NUM_CHANNEL  (N),
        .CHANNEL_WIDTH(W),
        .CH_CNT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_valid    (ch_valid),
        .ch_ready    (ch_ready),
        .ch_data     (ch_data),
        .ch_last     (ch_last),
        .fout_valid  (fout_valid),
        .fout_ready  (fout_ready),
        .features_top(features_top),
        .frame_err   (frame_err)
    );

    // Capture handshaken frames and error pulses mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && fout_valid === 1'b1 && fout_ready === 1'b1) out_q.push_back(features_top);
        if (rst === 1'b1 && frame_err === 1'b1) err_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [W-1:0] beat_data(input int seed, input int k);
        int v;
        v = k * (seed | 1) + seed + (k >> 3) * seed;
        return W'(v % 4);
    endfunction

    function automatic logic [FW-1:0] make_frame(input int seed);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) f[(N - k) * W - 1 -: W] = beat_data(seed, k);
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [W-1:0] d, input logic l);
        int guard;
        guard    = 0;
        ch_valid = 1'b1;
        ch_data  = d;
        ch_last  = l;
        while (ch_ready !== 1'b1 && guard < 1000) begin
            tick(1);
            guard++;
        end
        if (guard >= 1000) begin
            checks++;
            failures++;
            $display("FAIL ch_ready_timeout: ch_ready=%b after %0d cycles, required 1", ch_ready, guard);
        end
        tick(1);
        ch_valid = 1'b0;
        ch_last  = 1'b0;
    endtask

    task automatic send_frame(input int seed, input int nbeats, input int last_at, input bit gaps);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
            drive_beat(beat_data(seed, k), k == last_at);
        end
    endtask

    task automatic test_reset;
        rst        = 1'b0;
        ch_valid   = 1'b0;
        ch_data    = '0;
        ch_last    = 1'b0;
        fout_ready = 1'b0;
        tick(3);
        checks++;
        if (fout_valid !== 1'b0) begin failures++; $display("FAIL reset_fout_valid: got %b required 0", fout_valid); end
        checks++;
        if (features_top !== '0) begin failures++; $display("FAIL reset_features: got %h required 0", features_top); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
        rst = 1'b1;
        tick(1);
        checks++;
        if (ch_ready !== 1'b1) begin failures++; $display("FAIL reset_ch_ready: got %b required 1", ch_ready); end
    endtask

    task automatic test_single_frame;
        logic [FW-1:0] got;
        fout_ready = 1'b1;
        out_q.delete();
        err_cnt = 0;
        send_frame(0, N, N - 1, 1'b0);
        checks++;
        if (fout_valid !== 1'b1) begin failures++; $display("FAIL t1_latency: fout_valid=%b required 1", fout_valid); end
        checks++;
        if (features_top !== make_frame(0)) begin failures++; $display("FAIL t1_data: got %h required %h", features_top, make_frame(0)); end
        tick(2);
        checks++;
        if (fout_valid !== 1'b0) begin failures++; $display("FAIL t1_valid_drop: got %b required 0", fout_valid); end
        checks++;
        if (out_q.size() != 1) begin failures++; $display("FAIL t1_count: got %0d frames required 1", out_q.size()); end
        if (out_q.size() >= 1) begin
            got = out_q[0];
            checks++;
            if (got[FW-1 -: 2] !== 2'd0) begin failures++; $display("FAIL t1_msb_slice: got %0d required 0", got[FW-1 -: 2]); end
            checks++;
            if (got[1:0] !== 2'd1) begin failures++; $display("FAIL t1_lsb_slice: got %0d required 1", got[1:0]); end
        end
        checks++;
        if (err_cnt != 0) begin failures++; $display("FAIL t1_frame_err: got %0d pulses required 0", err_cnt); end
    endtask

    task automatic test_backpressure;
        fout_ready = 1'b0;
        out_q.delete();
        send_frame(1, N, N - 1, 1'b0);
        send_frame(2, N, N - 1, 1'b0);
        checks++;
        if (ch_ready !== 1'b0) begin failures++; $display("FAIL t2_hold_ready: got %b required 0", ch_ready); end
        tick(4);
        checks++;
        if (fout_valid !== 1'b1) begin failures++; $display("FAIL t2_hold_valid: got %b required 1", fout_valid); end
        checks++;
        if (features_top !== make_frame(1)) begin failures++; $display("FAIL t2_stable: got %h required %h", features_top, make_frame(1)); end
        checks++;
        if (ch_ready !== 1'b0) begin failures++; $display("FAIL t2_still_hold: got %b required 0", ch_ready); end
        fout_ready = 1'b1;
        tick(1);
        checks++;
        if (ch_ready !== 1'b1) begin failures++; $display("FAIL t2_ready_after_transfer: got %b required 1", ch_ready); end
        checks++;
        if (fout_valid !== 1'b1) begin failures++; $display("FAIL t2_valid_continuous: got %b required 1", fout_valid); end
        checks++;
        if (features_top !== make_frame(2)) begin failures++; $display("FAIL t2_second: got %h required %h", features_top, make_frame(2)); end
        tick(1);
        checks++;
        if (fout_valid !== 1'b0) begin failures++; $display("FAIL t2_drained: got %b required 0", fout_valid); end
        send_frame(3, N, N - 1, 1'b0);
        tick(2);
        checks++;
        if (out_q.size() != 3) begin
            failures++;
            $display("FAIL t2_count: got %0d frames required 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_q[i] !== make_frame(i + 1)) begin failures++; $display("FAIL t2_order[%0d]: got %h required %h", i, out_q[i], make_frame(i + 1)); end
            end
        end
    endtask

    task automatic test_short_frame;
        fout_ready = 1'b1;
        out_q.delete();
        err_cnt = 0;
        send_frame(3, 101, 100, 1'b0);
        checks++;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL t3_err_pulse: got %b required 1", frame_err); end
        tick(1);
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL t3_err_width: got %b required 0", frame_err); end
        send_frame(4, N, N - 1, 1'b0);
        tick(2);
        checks++;
        if (out_q.size() != 1) begin
            failures++;
            $display("FAIL t3_count: got %0d frames required 1", out_q.size());
        end else begin
            checks++;
            if (out_q[0] !== make_frame(4)) begin failures++; $display("FAIL t3_data: got %h required %h", out_q[0], make_frame(4)); end
        end
        checks++;
        if (err_cnt != 1) begin failures++; $display("FAIL t3_err_count: got %0d required 1", err_cnt); end
    endtask

    task automatic test_long_frame;
        fout_ready = 1'b1;
        out_q.delete();
        err_cnt = 0;
        send_frame(5, N, -1, 1'b0);
        checks++;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL t4_err_pulse: got %b required 1", frame_err); end
        send_frame(6, 5, 4, 1'b0);
        tick(2);
        checks++;
        if (out_q.size() != 0) begin failures++; $display("FAIL t4_drain_emit: got %0d frames required 0", out_q.size()); end
        send_frame(7, N, N - 1, 1'b0);
        tick(2);
        checks++;
        if (out_q.size() != 1) begin
            failures++;
            $display("FAIL t4_count: got %0d frames required 1", out_q.size());
        end else begin
            checks++;
            if (out_q[0] !== make_frame(7)) begin failures++; $display("FAIL t4_data: got %h required %h", out_q[0], make_frame(7)); end
        end
        checks++;
        if (err_cnt != 1) begin failures++; $display("FAIL t4_err_count: got %0d required 1", err_cnt); end
    endtask

    task automatic test_reset_midframe;
        fout_ready = 1'b0;
        out_q.delete();
        err_cnt = 0;
        send_frame(8, N, N - 1, 1'b0);
        send_frame(9, 50, -1, 1'b0);
        rst = 1'b0;
        tick(1);
        checks++;
        if (fout_valid !== 1'b0) begin failures++; $display("FAIL t5_fout_valid: got %b required 0", fout_valid); end
        checks++;
        if (features_top !== '0) begin failures++; $display("FAIL t5_features: got %h required 0", features_top); end
        rst = 1'b1;
        fout_ready = 1'b1;
        tick(1);
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL t5_frame_err: got %b required 0", frame_err); end
        send_frame(10, N, N - 1, 1'b0);
        tick(2);
        checks++;
        if (out_q.size() != 1) begin
            failures++;
            $display("FAIL t5_count: got %0d frames required 1", out_q.size());
        end else begin
            checks++;
            if (out_q[0] !== make_frame(10)) begin failures++; $display("FAIL t5_data: got %h required %h", out_q[0], make_frame(10)); end
        end
        checks++;
        if (err_cnt != 0) begin failures++; $display("FAIL t5_err_count: got %0d required 0", err_cnt); end
    endtask

    task automatic test_back_to_back;
        fout_ready = 1'b1;
        out_q.delete();
        err_cnt = 0;
        for (int f = 0; f < 10; f++) send_frame(20 + f, N, N - 1, 1'b1);
        tick(3);
        checks++;
        if (out_q.size() != 10) begin
            failures++;
            $display("FAIL t6_count: got %0d frames required 10", out_q.size());
        end else begin
            for (int f = 0; f < 10; f++) begin
                checks++;
                if (out_q[f] !== make_frame(20 + f)) begin failures++; $display("FAIL t6_frame[%0d]: got %h required %h", f, out_q[f], make_frame(20 + f)); end
            end
        end
        checks++;
        if (err_cnt != 0) begin failures++; $display("FAIL t6_err_count: got %0d required 0", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
